// File: rtl/seg_display_scanner.sv
// seg_display_scanner: latches the CPU syscall display value, picks one of four
// 32-bit sources, snapshots it once per scan frame and multiplexes the eight
// hex digits onto a common-anode seven-segment display (active-low anodes and
// cathodes, digit 0 rightmost).
module seg_display_scanner #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        led_cpu_enable,
  input  logic [31:0] led_data_in,
  input  logic [31:0] total_cycles,
  input  logic [31:0] condi_branch_num,
  input  logic [31:0] uncondi_branch_num,
  input  logic [1:0]  disp_sel,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat,
  output logic        led_valid
);

  // 24 bits covers the largest legal divider (2^24 cycles per digit)
  localparam logic [23:0] PRESC_LAST = 24'(SCAN_DIV - 1);

  logic [23:0] prescaler;
  logic        tick;
  logic [2:0]  idx;
  logic [31:0] latched;
  logic [31:0] snap;
  logic        snap_dp;
  logic [31:0] src_value;
  logic [3:0]  nibble;
  logic [6:0]  seg_code;

  assign tick = (prescaler == PRESC_LAST);

  // Digit dwell prescaler: 0..SCAN_DIV-1, wrapping on tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       prescaler <= '0;
    else if (tick) prescaler <= '0;
    else           prescaler <= prescaler + 24'd1;
  end

  // Syscall latch; a held strobe re-latches every cycle, valid is sticky
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latched   <= '0;
      led_valid <= 1'b0;
    end else if (led_cpu_enable) begin
      latched   <= led_data_in;
      led_valid <= 1'b1;
    end
  end

  // Digit index advances once per dwell, wrapping 7 -> 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       idx <= '0;
    else if (tick) idx <= idx + 3'd1;
  end

  // Source mux feeding the frame snapshot
  always_comb begin
    src_value = latched;
    case (disp_sel)
      2'd0:    src_value = latched;
      2'd1:    src_value = total_cycles;
      2'd2:    src_value = condi_branch_num;
      default: src_value = uncondi_branch_num;
    endcase
  end

  // Frame snapshot at the wrap edge; the dp flag marks "syscall source, nothing latched yet"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap    <= '0;
      snap_dp <= 1'b1;
    end else if (tick && (idx == 3'd7)) begin
      snap    <= src_value;
      snap_dp <= (disp_sel == 2'd0) && !led_valid;
    end
  end

  assign nibble = snap[{idx, 2'b00} +: 4];

  // Hex to active-low segments, bit 0 = a .. bit 6 = g
  always_comb begin
    seg_code = 7'h7F;
    case (nibble)
      4'h0: seg_code = 7'h40;
      4'h1: seg_code = 7'h79;
      4'h2: seg_code = 7'h24;
      4'h3: seg_code = 7'h30;
      4'h4: seg_code = 7'h19;
      4'h5: seg_code = 7'h12;
      4'h6: seg_code = 7'h02;
      4'h7: seg_code = 7'h78;
      4'h8: seg_code = 7'h00;
      4'h9: seg_code = 7'h10;
      4'hA: seg_code = 7'h08;
      4'hB: seg_code = 7'h03;
      4'hC: seg_code = 7'h46;
      4'hD: seg_code = 7'h21;
      4'hE: seg_code = 7'h06;
      default: seg_code = 7'h0E;
    endcase
  end

  // Registered display drive; blank while in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_an  <= 8'hFF;
      seg_cat <= 8'hFF;
    end else begin
      seg_an  <= ~(8'h01 << idx);
      seg_cat <= {~((idx == 3'd0) && snap_dp), seg_code};
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner: one instance with SCAN_DIV=4 for the
// main scenarios and one with SCAN_DIV=1 for the every-cycle-tick corner.
module tb_seg_display_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        led_cpu_enable;
  logic [31:0] led_data_in;
  logic [31:0] total_cycles;
  logic [31:0] condi_branch_num;
  logic [31:0] uncondi_branch_num;
  logic [1:0]  disp_sel;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;
  logic        led_valid;

  logic        led_cpu_enable1;
  logic [31:0] led_data_in1;
  logic [1:0]  disp_sel1;
  logic [7:0]  seg_an1;
  logic [7:0]  seg_cat1;
  logic        led_valid1;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  localparam logic [63:0] SYS_OLD  = 64'hC0F9A4B08883C6A1; // 0123ABCD, digit 0 in low byte
  localparam logic [63:0] SYS_NEW  = 64'hF8829299B0A4F9C0; // 76543210
  localparam logic [63:0] ALL_F    = 64'h8E8E8E8E8E8E8E8E; // FFFFFFFF
  localparam logic [63:0] CONDI    = 64'h80908883C6A1868E; // 89ABCDEF
  localparam logic [63:0] FAST_VAL = 64'h82F8809088_83C6A1; // 6789ABCD

  seg_display_scanner #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .led_cpu_enable(led_cpu_enable), .led_data_in(led_data_in),
    .total_cycles(total_cycles), .condi_branch_num(condi_branch_num),
    .uncondi_branch_num(uncondi_branch_num), .disp_sel(disp_sel),
    .seg_an(seg_an), .seg_cat(seg_cat), .led_valid(led_valid)
  );

  seg_display_scanner #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .rst(rst),
    .led_cpu_enable(led_cpu_enable1), .led_data_in(led_data_in1),
    .total_cycles(total_cycles), .condi_branch_num(condi_branch_num),
    .uncondi_branch_num(uncondi_branch_num), .disp_sel(disp_sel1),
    .seg_an(seg_an1), .seg_cat(seg_cat1), .led_valid(led_valid1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  // Holds each digit for its full dwell and checks it on the last dwell cycle
  task automatic check_digits(input string tag, input int lo, input int hi, input logic [63:0] exp);
    logic [7:0] an_exp;
    for (int k = lo; k <= hi; k++) begin
      repeat (4) step();
      an_exp = ~(8'h01 << k);
      chk({tag, "_cat"}, seg_cat, exp[8*k +: 8]);
      chk({tag, "_an"}, seg_an, an_exp);
    end
  endtask

  initial begin
    logic [7:0]  ea;
    logic [7:0]  ec;
    logic [31:0] dval;
    int          k;

    rst = 1'b1;
    led_cpu_enable = 1'b0; led_data_in = '0;
    total_cycles = '0; condi_branch_num = '0; uncondi_branch_num = '0;
    disp_sel = 2'd0;
    led_cpu_enable1 = 1'b0; led_data_in1 = '0; disp_sel1 = 2'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #3;
    chk("rst_an", seg_an, 8'hFF);
    chk("rst_cat", seg_cat, 8'hFF);
    chk("rst_valid", {7'b0, led_valid}, 8'h00);
    chk("rst_an1", seg_an1, 8'hFF);
    rst = 1'b0;
    cyc = 0;

    // Free-run scan order: both instances, blank syscall source shows 0 with dp on digit 0
    for (int n = 1; n <= 40; n++) begin
      step();
      k  = ((n - 1) / 4) % 8;
      ea = ~(8'h01 << k);
      ec = (k == 0) ? 8'h40 : 8'hC0;
      chk("scan_an", seg_an, ea);
      chk("scan_cat", seg_cat, ec);
      k  = (n - 1) % 8;
      ea = ~(8'h01 << k);
      ec = (k == 0) ? 8'h40 : 8'hC0;
      chk("scan1_an", seg_an1, ea);
      chk("scan1_cat", seg_cat1, ec);
    end

    // Syscall strobe for one cycle
    led_data_in = 32'h0123ABCD;
    led_cpu_enable = 1'b1;
    step();
    led_cpu_enable = 1'b0;
    led_data_in = 32'hDEADBEEF;
    chk("latch_valid", {7'b0, led_valid}, 8'h01);
    run_to(64);
    check_digits("sys", 0, 7, SYS_OLD);

    // Source select takes effect only at the next frame wrap
    disp_sel = 2'd1;
    total_cycles = 32'hFFFFFFFF;
    check_digits("sel_hold", 0, 7, SYS_OLD);
    check_digits("sel_tot", 0, 3, ALL_F);
    disp_sel = 2'd2;
    condi_branch_num = 32'h89ABCDEF;
    total_cycles = 32'h00000000;
    check_digits("sel_mid", 4, 7, ALL_F);
    check_digits("sel_condi", 0, 7, CONDI);

    // Strobe on the frame-wrap edge: old value this frame, new value next frame
    disp_sel = 2'd0;
    run_to(223);
    led_data_in = 32'h76543210;
    led_cpu_enable = 1'b1;
    step();
    led_cpu_enable = 1'b0;
    chk("wrap_valid", {7'b0, led_valid}, 8'h01);
    check_digits("wrap_old", 0, 7, SYS_OLD);
    check_digits("wrap_new", 0, 7, SYS_NEW);

    // Asynchronous reset mid-cycle
    #3;
    rst = 1'b1;
    #1;
    chk("arst_an", seg_an, 8'hFF);
    chk("arst_cat", seg_cat, 8'hFF);
    chk("arst_valid", {7'b0, led_valid}, 8'h00);
    chk("arst_an1", seg_an1, 8'hFF);
    chk("arst_valid1", {7'b0, led_valid1}, 8'h00);
    @(posedge clk);
    #2;
    rst = 1'b0;
    disp_sel1 = 2'd0;
    led_cpu_enable1 = 1'b1;
    led_data_in1 = 32'h01234567;
    cyc = 0;

    // SCAN_DIV=1 with a held strobe and data changing every cycle
    for (int c = 1; c <= 16; c++) begin
      step();
      dval = 32'h01234567 + 32'(c) * 32'h11111111;
      led_data_in1 = dval;
      if (c == 1) begin
        chk("post_an", seg_an, 8'hFE);
        chk("post_cat", seg_cat, 8'h40);
        chk("fast_valid", {7'b0, led_valid1}, 8'h01);
        chk("fast_first_cat", seg_cat1, 8'h40);
      end
      if (c >= 9) begin
        k  = c - 9;
        ea = ~(8'h01 << k);
        chk("fast_cat", seg_cat1, FAST_VAL[8*k +: 8]);
        chk("fast_an", seg_an1, ea);
      end
    end
    led_cpu_enable1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
